// File: rtl/lbm_streamer_if.sv
// Collider-to-streamer handshake plus the memory write port of the LBM streamer.
// The master drives cells in and observes writes; the slave is the streamer itself.
interface lbm_streamer_if #(
  parameter int unsigned XW     = 6,
  parameter int unsigned YW     = 5,
  parameter int unsigned ADDR_W = 4 + XW + YW
);
  logic              in_valid;
  logic              in_ready;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic              in_last;
  logic [15:0]       f_null;
  logic [15:0]       f_n;
  logic [15:0]       f_ne;
  logic [15:0]       f_e;
  logic [15:0]       f_se;
  logic [15:0]       f_s;
  logic [15:0]       f_sw;
  logic [15:0]       f_w;
  logic [15:0]       f_nw;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output in_valid, in_x, in_y, in_last,
    output f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last,
    input  f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/lbm_streamer.sv
// LBM push-streaming stage: takes one cell's nine post-collision distributions and
// serialises them into nine memory writes (dir 0..8), each addressed to the neighbour
// cell the distribution propagates to. x always wraps; y wraps unless the optional
// macro LBM_STREAMER_BOUNCEBACK_EN is defined, in which case rows 0 and NY-1 are
// no-slip walls and out-of-domain directions are reflected into the source cell.
module lbm_streamer #(
  parameter int unsigned XW     = 6,
  parameter int unsigned YW     = 5,
  parameter int unsigned ADDR_W = 4 + XW + YW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  lbm_streamer_if.slave   bus_io,
  output logic            busy_o,
  output logic            frame_done_o
);

  localparam int unsigned AddrNatW = 4 + XW + YW;
  localparam logic [3:0]  DirLast  = 4'd8;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e        state_q;
  logic [3:0]    dir_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          last_q;
  logic [15:0]   f_q [9];
  logic          frame_done_q;

  logic          in_ready;
  logic          accept;
  logic          at_last_dir;

  logic          dx_pos, dx_neg, dy_pos, dy_neg;
  logic [XW-1:0] x_nb;
  logic [YW-1:0] y_nb;
  logic [3:0]    slot;
  logic [XW-1:0] x_tgt;
  logic [YW-1:0] y_tgt;
  logic [AddrNatW-1:0] addr_nat;

  // Ready in IDLE and on the dir-8 write so cells can follow back-to-back.
  always_comb begin
    at_last_dir = (state_q == StWrite) && (dir_q == DirLast);
    in_ready    = !rst_i && ((state_q == StIdle) || at_last_dir);
    accept      = bus_io.in_valid && in_ready;
  end

  // Streaming FSM: capture on accept, walk dir 0..8, flag end of frame after dir 8.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      dir_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) f_q[i] <= '0;
    end else begin
      frame_done_q <= at_last_dir && last_q;
      if (accept) begin
        state_q <= StWrite;
        dir_q   <= '0;
        x_q     <= bus_io.in_x;
        y_q     <= bus_io.in_y;
        last_q  <= bus_io.in_last;
        f_q[0]  <= bus_io.f_null;
        f_q[1]  <= bus_io.f_n;
        f_q[2]  <= bus_io.f_ne;
        f_q[3]  <= bus_io.f_e;
        f_q[4]  <= bus_io.f_se;
        f_q[5]  <= bus_io.f_s;
        f_q[6]  <= bus_io.f_sw;
        f_q[7]  <= bus_io.f_w;
        f_q[8]  <= bus_io.f_nw;
      end else if (state_q == StWrite) begin
        if (dir_q == DirLast) begin
          state_q <= StIdle;
          dir_q   <= '0;
        end else begin
          dir_q <= dir_q + 4'd1;
        end
      end
    end
  end

  // Decode the lattice velocity of the current direction.
  always_comb begin
    dx_pos = 1'b0;
    dx_neg = 1'b0;
    dy_pos = 1'b0;
    dy_neg = 1'b0;
    case (dir_q)
      4'd1: dy_pos = 1'b1;
      4'd2: begin dx_pos = 1'b1; dy_pos = 1'b1; end
      4'd3: dx_pos = 1'b1;
      4'd4: begin dx_pos = 1'b1; dy_neg = 1'b1; end
      4'd5: dy_neg = 1'b1;
      4'd6: begin dx_neg = 1'b1; dy_neg = 1'b1; end
      4'd7: dx_neg = 1'b1;
      4'd8: begin dx_neg = 1'b1; dy_pos = 1'b1; end
      default: ;
    endcase
  end

  // Neighbour coordinates; natural overflow gives the periodic wrap.
  always_comb begin
    x_nb = x_q;
    y_nb = y_q;
    if (dx_pos) x_nb = x_q + XW'(1);
    if (dx_neg) x_nb = x_q - XW'(1);
    if (dy_pos) y_nb = y_q + YW'(1);
    if (dy_neg) y_nb = y_q - YW'(1);
  end

`ifdef LBM_STREAMER_BOUNCEBACK_EN
  logic [2:0] opp_lo;
  logic [3:0] dir_opp;
  logic       wall_hit;

  // A y step off the domain reflects into the source cell's opposite slot.
  always_comb begin
    opp_lo   = dir_q[2:0] + 3'd3;
    dir_opp  = (dir_q == 4'd0) ? 4'd0 : ({1'b0, opp_lo} + 4'd1);
    wall_hit = (dy_pos && (y_q == {YW{1'b1}})) || (dy_neg && (y_q == '0));
    slot     = wall_hit ? dir_opp : dir_q;
    x_tgt    = wall_hit ? x_q : x_nb;
    y_tgt    = wall_hit ? y_q : y_nb;
  end
`else
  // Fully periodic domain: the neighbour is always the target.
  always_comb begin
    slot  = dir_q;
    x_tgt = x_nb;
    y_tgt = y_nb;
  end
`endif

  // Write port driven purely from registered state; zero when not writing.
  always_comb begin
    addr_nat = {slot, y_tgt, x_tgt};
    bus_io.in_ready = in_ready;
    bus_io.wr_en    = (state_q == StWrite);
    bus_io.wr_addr  = '0;
    bus_io.wr_data  = '0;
    if (state_q == StWrite) begin
      bus_io.wr_addr = ADDR_W'(addr_nat);
      bus_io.wr_data = (dir_q <= DirLast) ? f_q[dir_q] : 16'h0000;
    end
    busy_o       = (state_q == StWrite);
    frame_done_o = frame_done_q;
  end

endmodule

// File: tb/tb_lbm_streamer.sv
// Directed bench for lbm_streamer with XW=3, YW=3 (addr = dir*64 + y*8 + x).
// Builds with or without LBM_STREAMER_BOUNCEBACK_EN; wall-row expectations follow it.
module tb_lbm_streamer;

  localparam int NV = 6;

  logic clk;
  logic rst;
  logic busy;
  logic frame_done;

  lbm_streamer_if #(.XW(3), .YW(3), .ADDR_W(10)) bus ();

  lbm_streamer #(.XW(3), .YW(3), .ADDR_W(10)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_io       (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      x;
    logic [2:0]      y;
    logic            last;
    logic [8:0][9:0] addr;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mkv(input int x, input int y, input int last,
                               input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5,
                               input int a6, input int a7, input int a8);
    vec_t v;
    v.x       = 3'(x);
    v.y       = 3'(y);
    v.last    = 1'(last);
    v.addr[0] = 10'(a0);
    v.addr[1] = 10'(a1);
    v.addr[2] = 10'(a2);
    v.addr[3] = 10'(a3);
    v.addr[4] = 10'(a4);
    v.addr[5] = 10'(a5);
    v.addr[6] = 10'(a6);
    v.addr[7] = 10'(a7);
    v.addr[8] = 10'(a8);
    return v;
  endfunction

  // Cell i, direction d carries ((d+1) << 8) | i; cell 0 gives 0x0100..0x0900.
  function automatic logic [15:0] fval(input int i, input int d);
    return 16'(((d + 1) << 8) | i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cell(input int i);
    bus.in_valid = 1'b1;
    bus.in_x     = vecs[i].x;
    bus.in_y     = vecs[i].y;
    bus.in_last  = vecs[i].last;
    bus.f_null   = fval(i, 0);
    bus.f_n      = fval(i, 1);
    bus.f_ne     = fval(i, 2);
    bus.f_e      = fval(i, 3);
    bus.f_se     = fval(i, 4);
    bus.f_s      = fval(i, 5);
    bus.f_sw     = fval(i, 6);
    bus.f_w      = fval(i, 7);
    bus.f_nw     = fval(i, 8);
  endtask

  initial begin
    vecs[0] = mkv(3, 3, 0, 27, 99, 164, 220, 276, 339, 402, 474, 546);
    vecs[1] = mkv(7, 5, 1, 47, 119, 176, 232, 288, 359, 422, 494, 566);
    vecs[2] = mkv(0, 1, 0, 8, 80, 145, 201, 257, 320, 391, 463, 535);
`ifdef LBM_STREAMER_BOUNCEBACK_EN
    vecs[3] = mkv(7, 7, 0, 63, 383, 447, 248, 304, 375, 438, 510, 319);
    vecs[4] = mkv(2, 7, 0, 58, 378, 442, 251, 307, 370, 433, 505, 314);
    vecs[5] = mkv(4, 0, 1, 4, 76, 141, 197, 516, 68, 132, 451, 523);
`else
    vecs[3] = mkv(7, 7, 0, 63, 71, 128, 248, 304, 375, 438, 510, 518);
    vecs[4] = mkv(2, 7, 0, 58, 66, 131, 251, 307, 370, 433, 505, 513);
    vecs[5] = mkv(4, 0, 1, 4, 317, 141, 197, 317, 380, 443, 451, 523);
    vecs[5].addr[1] = 10'd76;
`endif

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_last = 1'b0;
    bus.f_null = '0; bus.f_n = '0; bus.f_ne = '0; bus.f_e = '0; bus.f_se = '0;
    bus.f_s = '0; bus.f_sw = '0; bus.f_w = '0; bus.f_nw = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset wr_data", 32'(bus.wr_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 32'(bus.in_ready), 32'd1);

    // Table run: every cell presented while the previous one writes -> gap-free stream.
    drive_cell(0);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i + 1 < NV) drive_cell(i + 1);
      else bus.in_valid = 1'b0;
      for (int d = 0; d < 9; d++) begin
        chk($sformatf("c%0d d%0d wr_en", i, d), 32'(bus.wr_en), 32'd1);
        chk($sformatf("c%0d d%0d wr_addr", i, d), 32'(bus.wr_addr), 32'(vecs[i].addr[d]));
        chk($sformatf("c%0d d%0d wr_data", i, d), 32'(bus.wr_data), 32'(fval(i, d)));
        chk($sformatf("c%0d d%0d busy", i, d), 32'(busy), 32'd1);
        chk($sformatf("c%0d d%0d in_ready", i, d), 32'(bus.in_ready), (d == 8) ? 32'd1 : 32'd0);
        chk($sformatf("c%0d d%0d frame_done", i, d), 32'(frame_done),
            (d == 0 && i > 0 && vecs[(i > 0) ? i - 1 : 0].last) ? 32'd1 : 32'd0);
        if (d < 8) @(negedge clk);
      end
    end
    @(negedge clk);
    chk("drain wr_en", 32'(bus.wr_en), 32'd0);
    chk("drain busy", 32'(busy), 32'd0);
    chk("drain in_ready", 32'(bus.in_ready), 32'd1);
    chk("drain frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("frame_done one cycle", 32'(frame_done), 32'd0);

    // Reset during the dir-4 write: remaining writes dropped, fresh cell restarts at dir 0.
    drive_cell(0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst dir4 wr_en", 32'(bus.wr_en), 32'd1);
    chk("pre-rst dir4 wr_addr", 32'(bus.wr_addr), 32'd276);
    rst = 1'b1;
    @(negedge clk);
    chk("rst wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    @(negedge clk);
    chk("rst hold wr_en", 32'(bus.wr_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("post-rst wr_en", 32'(bus.wr_en), 32'd0);
    drive_cell(2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("restart d0 wr_addr", 32'(bus.wr_addr), 32'd8);
    chk("restart d0 wr_data", 32'(bus.wr_data), 32'(fval(2, 0)));
    @(negedge clk);
    chk("restart d1 wr_addr", 32'(bus.wr_addr), 32'd80);
    repeat (8) @(negedge clk);
    chk("restart done wr_en", 32'(bus.wr_en), 32'd0);
    chk("restart done frame_done", 32'(frame_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbm_streamer.md
# lbm_streamer

Push-streaming stage that sits directly downstream of the LBM collider. It accepts one cell's nine post-collision distributions (Q3.13) per handshake. It serialises them into nine single-port memory writes, one per cycle, each aimed at the neighbour cell the distribution propagates to. Address generation applies periodic wrap in x and either periodic wrap or bounce-back walls in y.

## Interface
Parameters:
- XW, default 6: x coordinate width; NX = 2**XW
- YW, default 5: y coordinate width; NY = 2**YW
- ADDR_W, default 4+XW+YW: write address width; address = {dir[3:0], y[YW-1:0], x[XW-1:0]}

Ports:
- clk, input, 1: single clock, rising edge
- rst, input, 1: reset, synchronous, active-high
- in_valid, input, 1: cell data valid
- in_ready, output, 1: stage can accept a cell
- in_x, input, XW: source cell x
- in_y, input, YW: source cell y
- in_last, input, 1: last cell of the frame
- f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, input, 16 each: post-collision distributions, signed Q3.13
- wr_en, output, 1: memory write strobe
- wr_addr, output, ADDR_W: write address
- wr_data, output, 16: write data
- busy, output, 1: high while in WRITE
- frame_done, output, 1: one-cycle pulse after the final write of an in_last cell

## Operation
- Direction index and velocity: 0 null (0,0), 1 n (0,+1), 2 ne (+1,+1), 3 e (+1,0), 4 se (+1,-1), 5 s (0,-1), 6 sw (-1,-1), 7 w (-1,0), 8 nw (-1,+1).
- Opposite direction: opp(0)=0; for i≥1, opp(i)=((i+3) mod 8)+1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture the nine f values, x, y and last; set dir=0; go to WRITE.
  - WRITE: emit one write per cycle for dir 0..8 in ascending order, with wr_data = f[dir] and target = (x+cx, y+cy).
- Leaving WRITE at dir==8:
  - If in_valid is high, accept the next cell in that same cycle (in_ready=1 at dir==8) and restart at dir=0.
  - Otherwise return to IDLE.
- x arithmetic is modulo NX: natural XW-bit overflow, no comparators.
- y arithmetic is per the Configuration section.
- Upstream must hold in_valid and its data stable until accepted. in_valid while in_ready=0 is ignored.
- wr_en, wr_addr and wr_data are combinational from registered state only. There is no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, dir 0, captured x/y/data 0. While rst is high: in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, frame_done 0.
- Latency: for a handshake at edge k, wr_en is high in the 9 cycles following edge k (dir 0 through dir 8).
- Throughput: 9 cycles per cell with back-to-back acceptance. Writes are gap-free across cells.
- frame_done is high for exactly the one cycle after the dir-8 write of an in_last cell. This holds even if the next cell is already being written.
- Reset mid-operation: the remaining writes of the current cell are dropped, no further wr_en is issued, and the cell is not replayed. in_ready is 1 in the first cycle after rst deasserts.

## Configuration
- Macro: LBM_STREAMER_BOUNCEBACK_EN.
- Defined: rows y=0 and y=NY-1 are no-slip walls. Any direction whose target y falls outside [0, NY-1] is instead written to the source cell (x, y) in slot opp(dir), with unchanged data. Write count and order are unchanged.
- Not defined: y arithmetic is modulo NY (fully periodic domain). No comparators are synthesised.

## Test plan
Addresses below use XW=3, YW=3: addr = dir*64 + y*8 + x.
- Interior cell (3,3), f_null..f_nw = 0x0100..0x0900:
  - dir 0 → addr 27, data 0x0100
  - dir 1 → addr 99 (3,4), data 0x0200
  - dir 2 → addr 164 (4,4), data 0x0300
  - dir 8 → addr 546 (2,4), data 0x0900
- Corner (7,7), periodic build: ne → addr 128 (0,0); e → addr 248 (0,7).
- Cell (2,7), n value 0x0200:
  - With LBM_STREAMER_BOUNCEBACK_EN: addr 378 (s slot, source cell).
  - Without: addr 66 (n slot, (2,0)).
- Two cells with in_valid held high → 18 consecutive wr_en cycles; in_ready is high only in IDLE and on the 9th cycle.
- Cell with in_last=1 followed by a non-last cell → frame_done high for exactly one cycle, the cycle after the 9th write, concurrent with the next cell's dir-0 write.
- rst asserted during the dir-4 write → wr_en=0 from the next cycle; in_ready=1 the first cycle after rst drops; a new cell restarts at dir 0.
